// File: rtl/pipe_pkg.sv
// Shared definitions for ready/valid pipeline stages: state encodings and
// the handshake helper used to form fire strobes.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_BUSY  = 2'b01,
    S_FULL  = 2'b10
  } pipe_state_e;

  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Ready/valid pipeline stage with one skid entry: fully registered in_ready,
// flush for squash, and a saturating stall-cycle counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             main_en_s, skid_en_s, main_sel_skid_s;
  logic             in_fire_s, out_fire_s;
  logic [WIDTH-1:0] main_q, skid_q, main_d_s;

  assign in_fire_s  = hs_fire(in_valid, in_ready_q);
  assign out_fire_s = hs_fire(out_valid_q, out_ready);

  always_comb begin
    state_d         = state_q;
    main_en_s       = 1'b0;
    skid_en_s       = 1'b0;
    main_sel_skid_s = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_fire_s) begin
          state_d   = S_BUSY;
          main_en_s = 1'b1;
        end
      end
      S_BUSY: begin
        if (in_fire_s && out_fire_s) begin
          main_en_s = 1'b1;
        end else if (in_fire_s) begin
          state_d   = S_FULL;
          skid_en_s = 1'b1;
        end else if (out_fire_s) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire_s) begin
          state_d         = S_BUSY;
          main_en_s       = 1'b1;
          main_sel_skid_s = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Squash drops both handshakes; payload registers keep stale contents.
    if (flush) begin
      state_d   = S_EMPTY;
      main_en_s = 1'b0;
      skid_en_s = 1'b0;
    end
    out_valid_d = (state_d == S_BUSY) || (state_d == S_FULL);
    in_ready_d  = (state_d != S_FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign main_d_s = main_sel_skid_s ? skid_q : in_data;

  flopenr #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en_s),
    .d     (main_d_s),
    .q     (main_q)
  );

  flopenr #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en_s),
    .d     (in_data),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

endmodule
